// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - parametrised stall/flush control with load scoreboard and memory-wait freeze
// Optional syscall drain stall enabled by defining HAZARD_SYSCALL_DRAIN_EN.
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_DELAY  = 1,
  parameter int CNT_W       = 3,
  parameter int DELAY_SLOT  = 1,
  parameter int WAIT_W      = 10,
  parameter int MEM_TIMEOUT = 1000
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  ID_Valid_IN,
  input  logic [REG_ADDR_W-1:0] ID_RegS_IN,
  input  logic                  ID_UseS_IN,
  input  logic [REG_ADDR_W-1:0] ID_RegT_IN,
  input  logic                  ID_UseT_IN,
  input  logic [REG_ADDR_W-1:0] ID_WriteReg_IN,
  input  logic                  ID_WriteEnable_IN,
  input  logic                  ID_IsLoad_IN,
  input  logic                  ID_Redirect_IN,
`ifdef HAZARD_SYSCALL_DRAIN_EN
  input  logic                  ID_Syscall_IN,
`endif
  input  logic                  MEM_Access_IN,
  input  logic                  MEM_Ready_IN,
  output logic [NUM_STAGES-2:0] STALL_OUT,
  output logic [NUM_STAGES-2:0] FLUSH_OUT,
  output logic                  PCStall_OUT,
  output logic                  LoadUseStall_OUT,
  output logic [WAIT_W-1:0]     MemWaitCycles_OUT,
  output logic                  MemTimeout_OUT
);

  localparam int                NREGS       = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0]  LOAD_CNT    = CNT_W'(LOAD_DELAY);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0]  cnt [NREGS];
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              timeout;
  logic              freeze;
  logic              hit;
  logic              drain;
  logic              id_stall;
  logic              issue;
  logic              wr_issue;

  assign freeze = MEM_Access_IN & ~MEM_Ready_IN;
  assign hit    = ID_Valid_IN &
                  ((ID_UseS_IN & (ID_RegS_IN != '0) & (cnt[ID_RegS_IN] != '0)) |
                   (ID_UseT_IN & (ID_RegT_IN != '0) & (cnt[ID_RegT_IN] != '0)));

`ifdef HAZARD_SYSCALL_DRAIN_EN
  logic [NUM_STAGES-3:0] drain_sr;
  logic                  cnt_busy;

  always_comb begin
    cnt_busy = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (cnt[i] != '0) cnt_busy = 1'b1;
    end
  end

  assign drain = ID_Valid_IN & ID_Syscall_IN & ((drain_sr != '0) | cnt_busy);

  // Tracks writers still in flight so a syscall sees a quiescent pipeline.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      drain_sr <= '0;
    end else if (!freeze) begin
      drain_sr <= {drain_sr[NUM_STAGES-4:0], issue & ID_WriteEnable_IN};
    end
  end
`else
  assign drain = 1'b0;
`endif

  assign id_stall = hit | drain;
  assign issue    = ID_Valid_IN & ~id_stall & ~freeze;
  assign wr_issue = issue & ID_WriteEnable_IN & (ID_WriteReg_IN != '0);

  always_comb begin
    STALL_OUT        = '0;
    FLUSH_OUT        = '0;
    PCStall_OUT      = 1'b0;
    LoadUseStall_OUT = 1'b0;
    if (!RESET) begin
      FLUSH_OUT = '1;
    end else if (freeze) begin
      STALL_OUT   = '1;
      PCStall_OUT = 1'b1;
    end else if (id_stall) begin
      PCStall_OUT      = 1'b1;
      STALL_OUT[0]     = 1'b1;
      FLUSH_OUT[1]     = 1'b1;
      LoadUseStall_OUT = 1'b1;
    end else if (ID_Redirect_IN && (DELAY_SLOT == 0)) begin
      FLUSH_OUT[0] = 1'b1;
    end
  end

  // A fresh write to a register overrides its countdown; ALU results are forwarded.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else if (!freeze) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_issue && (ID_WriteReg_IN == REG_ADDR_W'(i))) begin
          cnt[i] <= ID_IsLoad_IN ? LOAD_CNT : '0;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (freeze) begin
      wait_cnt <= wait_next;
      if (wait_next == TIMEOUT_VAL) timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign MemWaitCycles_OUT = wait_cnt;
  assign MemTimeout_OUT    = timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
// Instance a uses defaults; instance b uses LOAD_DELAY=3, DELAY_SLOT=0, MEM_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [4:0] rs;
  logic       use_s;
  logic [4:0] rt;
  logic       use_t;
  logic [4:0] wr;
  logic       we;
  logic       is_load;
  logic       redirect;
  logic       mem_access;
  logic       mem_ready;
`ifdef HAZARD_SYSCALL_DRAIN_EN
  logic       syscall = 1'b0;
`endif

  logic [3:0] a_stall, a_flush, b_stall, b_flush;
  logic       a_pc, a_lus, a_to, b_pc, b_lus, b_to;
  logic [9:0] a_wait, b_wait;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .CLOCK(clk), .RESET(rst_n),
    .ID_Valid_IN(valid), .ID_RegS_IN(rs), .ID_UseS_IN(use_s),
    .ID_RegT_IN(rt), .ID_UseT_IN(use_t), .ID_WriteReg_IN(wr),
    .ID_WriteEnable_IN(we), .ID_IsLoad_IN(is_load), .ID_Redirect_IN(redirect),
`ifdef HAZARD_SYSCALL_DRAIN_EN
    .ID_Syscall_IN(syscall),
`endif
    .MEM_Access_IN(mem_access), .MEM_Ready_IN(mem_ready),
    .STALL_OUT(a_stall), .FLUSH_OUT(a_flush), .PCStall_OUT(a_pc),
    .LoadUseStall_OUT(a_lus), .MemWaitCycles_OUT(a_wait), .MemTimeout_OUT(a_to)
  );

  pipeline_hazard_ctrl #(.LOAD_DELAY(3), .DELAY_SLOT(0), .MEM_TIMEOUT(8)) dut_b (
    .CLOCK(clk), .RESET(rst_n),
    .ID_Valid_IN(valid), .ID_RegS_IN(rs), .ID_UseS_IN(use_s),
    .ID_RegT_IN(rt), .ID_UseT_IN(use_t), .ID_WriteReg_IN(wr),
    .ID_WriteEnable_IN(we), .ID_IsLoad_IN(is_load), .ID_Redirect_IN(redirect),
`ifdef HAZARD_SYSCALL_DRAIN_EN
    .ID_Syscall_IN(syscall),
`endif
    .MEM_Access_IN(mem_access), .MEM_Ready_IN(mem_ready),
    .STALL_OUT(b_stall), .FLUSH_OUT(b_flush), .PCStall_OUT(b_pc),
    .LoadUseStall_OUT(b_lus), .MemWaitCycles_OUT(b_wait), .MemTimeout_OUT(b_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s, input logic us,
                        input logic [4:0] w, input logic e, input logic ld,
                        input logic rd);
    valid = v; rs = s; use_s = us; rt = 5'd0; use_t = 1'b0;
    wr = w; we = e; is_load = ld; redirect = rd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_access = 1'b0;
    mem_ready  = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_stall", a_stall, 4'b0000);
    chk("rst_flush", a_flush, 4'b1111);
    chk("rst_pc", a_pc, 1'b0);
    chk("rst_lus", a_lus, 1'b0);
    chk("rst_wait", a_wait, 10'd0);
    chk("rst_to", b_to, 1'b0);
    tick();
    rst_n = 1'b1;

    // load r8 then a reader of r8: a stalls once, b stalls three times
    set_id(1, 0, 0, 8, 1, 1, 0);
    chk("ld_issue_lus", a_lus, 1'b0);
    chk("ld_issue_flush", a_flush, 4'b0000);
    tick();
    set_id(1, 8, 1, 0, 0, 0, 0);
    chk("lu_a_pc", a_pc, 1'b1);
    chk("lu_a_stall", a_stall, 4'b0001);
    chk("lu_a_flush", a_flush, 4'b0010);
    chk("lu_a_lus", a_lus, 1'b1);
    chk("lu_b_lus1", b_lus, 1'b1);
    tick();
    chk("lu_a_done", a_lus, 1'b0);
    chk("lu_a_done_stall", a_stall, 4'b0000);
    chk("lu_b_lus2", b_lus, 1'b1);
    tick();
    chk("lu_b_lus3", b_lus, 1'b1);
    tick();
    chk("lu_b_done", b_lus, 1'b0);
    chk("lu_b_done_pc", b_pc, 1'b0);
    tick();

    // reader of a non-pending register
    set_id(1, 0, 0, 8, 1, 1, 0);
    tick();
    set_id(1, 9, 1, 0, 0, 0, 0);
    chk("r9_a_lus", a_lus, 1'b0);
    chk("r9_b_lus", b_lus, 1'b0);
    tick();

    // load r8, ALU write r8, read r8: WAW clears the countdown
    set_id(1, 0, 0, 8, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 8, 1, 0, 0);
    chk("waw_alu_lus", b_lus, 1'b0);
    tick();
    set_id(1, 8, 1, 0, 0, 0, 0);
    chk("waw_a_lus", a_lus, 1'b0);
    chk("waw_b_lus", b_lus, 1'b0);
    tick();

    // r0 is never tracked
    set_id(1, 0, 0, 0, 1, 1, 0);
    tick();
    set_id(1, 0, 1, 0, 0, 0, 0);
    chk("r0_a_lus", a_lus, 1'b0);
    chk("r0_b_lus", b_lus, 1'b0);
    tick();

    // five-cycle memory freeze overlapping a pending load-use
    set_id(1, 0, 0, 8, 1, 1, 0);
    tick();
    set_id(1, 8, 1, 0, 0, 0, 0);
    mem_access = 1'b1;
    mem_ready  = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("frz_a_stall", a_stall, 4'b1111);
      chk("frz_a_lus", a_lus, 1'b0);
      tick();
    end
    chk("frz_b_flush", b_flush, 4'b0000);
    chk("frz_b_pc", b_pc, 1'b1);
    chk("frz_wait5", a_wait, 10'd5);
    mem_ready = 1'b1;
    #1;
    chk("frz_after_lus", a_lus, 1'b1);
    chk("frz_after_stall", a_stall, 4'b0001);
    tick();
    chk("frz_wait0", a_wait, 10'd0);
    chk("frz_a_issued", a_lus, 1'b0);
    chk("frz_b_still", b_lus, 1'b1);
    chk("frz_b_no_to", b_to, 1'b0);
    mem_access = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // timeout on b after 8 wait cycles, sticky across a ready cycle
    set_id(1, 0, 0, 8, 1, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    mem_access = 1'b1;
    mem_ready  = 1'b0;
    #1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("to_wait", b_wait, i);
      chk("to_flag", b_to, (i >= 8) ? 1 : 0);
    end
    chk("to_a_flag", a_to, 1'b0);
    mem_ready = 1'b1;
    tick();
    chk("to_sticky", b_to, 1'b1);
    chk("to_wait_clr", b_wait, 10'd0);
    mem_ready = 1'b0;
    tick(); tick();
    chk("to_wait2", b_wait, 10'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wait", b_wait, 10'd0);
    chk("arst_to", b_to, 1'b0);
    chk("arst_flush", b_flush, 4'b1111);
    tick();
    rst_n = 1'b1;
    mem_access = 1'b0;
    set_id(1, 8, 1, 0, 0, 0, 0);
    chk("arst_no_pending", b_lus, 1'b0);
    tick();

    // redirect: b flushes IF/ID, a keeps the delay slot
    set_id(1, 0, 0, 0, 0, 0, 1);
    chk("rd_a_flush", a_flush, 4'b0000);
    chk("rd_b_flush", b_flush, 4'b0001);
    chk("rd_b_pc", b_pc, 1'b0);
    tick();
    set_id(1, 0, 0, 8, 1, 1, 0);
    tick();
    set_id(1, 8, 1, 0, 0, 0, 1);
    chk("rd_lu_b_flush", b_flush, 4'b0010);
    chk("rd_lu_b_stall", b_stall, 4'b0001);
    chk("rd_lu_a_flush", a_flush, 4'b0010);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
